// File: rtl/smc_seq.sv
// Sequential MOSFET calculator: evaluates I_D or gm per device descriptor, keeps the
// three largest or smallest values of a frame and emits one weighted, saturated result.
module smc_seq #(
  parameter int CH = 6,
  parameter int DW = 3,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] vgs,
  input  logic [DW-1:0] vds,
  output logic          out_valid,
  output logic [OW-1:0] out_n
);

  // Device values stay below 2^(3*DW+1); the weighted sum adds at most a factor of 12.
  localparam int NW = 3 * DW + 2;
  localparam int SW = NW + 4;
  localparam int XW = (SW > OW) ? SW : OW + 1;
  localparam int CW = $clog2(CH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(CH - 1);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [NW-1:0] DIV3 = NW'(3);
  localparam logic [XW-1:0] OMAX = XW'((64'd1 << OW) - 64'd1);

  function automatic logic [DW-1:0] overdrive(input logic [DW-1:0] g);
    return (g == '0) ? '0 : g - ONE;
  endfunction

  function automatic logic [NW-1:0] drain_current(input logic [DW-1:0] wi,
                                                  input logic [DW-1:0] gi,
                                                  input logic [DW-1:0] di);
    logic [NW-1:0] wx, vx, dx;
    wx = NW'(wi);
    vx = NW'(overdrive(gi));
    dx = NW'(di);
    if (vx > dx) return (wx * (((vx << 1) * dx) - (dx * dx))) / DIV3;
    return (wx * vx * vx) / DIV3;
  endfunction

  function automatic logic [NW-1:0] transcond(input logic [DW-1:0] wi,
                                              input logic [DW-1:0] gi,
                                              input logic [DW-1:0] di);
    logic [NW-1:0] wx, vx, dx;
    wx = NW'(wi);
    vx = NW'(overdrive(gi));
    dx = NW'(di);
    if (vx > dx) return ((wx * dx) << 1) / DIV3;
    return ((wx * vx) << 1) / DIV3;
  endfunction

  function automatic logic [XW-1:0] weighted(input logic          id_sel,
                                             input logic [NW-1:0] a,
                                             input logic [NW-1:0] b,
                                             input logic [NW-1:0] c);
    logic [XW-1:0] ax, bx, cx;
    ax = XW'(a);
    bx = XW'(b);
    cx = XW'(c);
    if (id_sel) return (XW'(3) * ax + XW'(4) * bx + XW'(5) * cx) / XW'(12);
    return (ax + bx + cx) / XW'(3);
  endfunction

  function automatic logic [OW-1:0] saturate(input logic [XW-1:0] x);
    return (x > OMAX) ? '1 : x[OW-1:0];
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_r;
  logic [1:0]    fill;
  logic [NW-1:0] n0, n1, n2;
  logic [NW-1:0] nn0, nn1, nn2;
  logic [NW-1:0] cand;
  logic [NW-1:0] id_p0, gm_p0;
  logic          vld_p0;
  logic          accept;

  assign in_ready = (state == IDLE) || (state == ACC);
  assign accept   = in_valid && in_ready;

  // Stage p0: evaluate both quantities of the accepted device
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0 <= drain_current(w, vgs, vds);
      gm_p0 <= transcond(w, vgs, vds);
    end
  end

  // Stage p1: sorted insertion into n0 >= n1 >= n2; equal values land behind existing ones
  always_comb begin
    cand = mode_r[0] ? id_p0 : gm_p0;
    nn0  = n0;
    nn1  = n1;
    nn2  = n2;
    if (fill == 2'd0) begin
      nn0 = cand;
    end else if (fill == 2'd1) begin
      if (cand > n0) begin
        nn0 = cand;
        nn1 = n0;
      end else begin
        nn1 = cand;
      end
    end else if (fill == 2'd2 || (mode_r[1] && cand > n2)) begin
      if (cand > n0) begin
        nn0 = cand;
        nn1 = n0;
        nn2 = n1;
      end else if (cand > n1) begin
        nn1 = cand;
        nn2 = n1;
      end else begin
        nn2 = cand;
      end
    end else if (!mode_r[1] && cand < n0) begin
      if (cand > n1) begin
        nn0 = cand;
      end else if (cand > n2) begin
        nn0 = n1;
        nn1 = cand;
      end else begin
        nn0 = n1;
        nn1 = n2;
        nn2 = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_r    <= '0;
      fill      <= '0;
      n0        <= '0;
      n1        <= '0;
      n2        <= '0;
      vld_p0    <= 1'b0;
      out_valid <= 1'b0;
      out_n     <= '0;
    end else begin
      vld_p0    <= accept;
      out_valid <= 1'b0;
      if (vld_p0) begin
        n0 <= nn0;
        n1 <= nn1;
        n2 <= nn2;
        if (fill != 2'd3) fill <= fill + 2'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            mode_r <= mode;
            cnt    <= CW'(1);
            state  <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= CALC;
          end
        end
        // The final insertion lands on the first CALC edge; the sum follows one cycle later
        CALC: begin
          if (!vld_p0) begin
            out_n     <= saturate(weighted(mode_r[0], n0, n1, n2));
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          fill  <= '0;
        end
      endcase
    end
  end

endmodule
